// File: rtl/vx_pending_instr_tracker_pkg.sv
// Shared constants for the pending-instruction tracker: counter width, perf counter width,
// and the width helper for per-warp commit popcounts.
package vx_pending_instr_tracker_pkg;

   localparam int PENDING_CTR_WIDTH = 6;
   typedef logic [PENDING_CTR_WIDTH-1:0] pending_ctr_t;

   localparam int PERF_CTR_BITS = 44;

   // Bits needed to hold a count of 0..n simultaneous commits.
   function automatic int dec_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/vx_commit_warp_decoder.sv
// Converts NUM_COMMITS (valid, eop, wid) commit tuples into a per-warp count of
// instructions retiring this cycle; packed as NUM_WARPS fields of DEC_W bits.
module vx_commit_warp_decoder
   import vx_pending_instr_tracker_pkg::*;
#(
   parameter int NUM_WARPS   = 8,
   parameter int NUM_COMMITS = 4,
   parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   parameter int DEC_W       = dec_width(NUM_COMMITS)
) (
   input  logic [NUM_COMMITS-1:0]          commit_valid,
   input  logic [NUM_COMMITS-1:0]          commit_eop,
   input  logic [NUM_COMMITS*NW_WIDTH-1:0] commit_wid,
   output logic [NUM_WARPS*DEC_W-1:0]      dec
);

   logic [DEC_W-1:0] dec_cnt [NUM_WARPS];

   // Only the final packet of an instruction retires it.
   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         dec_cnt[w] = '0;
         for (int i = 0; i < NUM_COMMITS; i++) begin
            if (commit_valid[i] && commit_eop[i]
                && (commit_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w))) begin
               dec_cnt[w] = dec_cnt[w] + DEC_W'(1);
            end
         end
      end
   end

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_pack
      assign dec[w*DEC_W +: DEC_W] = dec_cnt[w];
   end

endmodule

// File: rtl/vx_pending_instr_tracker.sv
// Per-warp count of issued-but-uncommitted instructions; drives the CSR alm_empty
// query and issue back-pressure. Optional perf counters under VX_PENDING_TRACKER_PERF_EN.
module vx_pending_instr_tracker
   import vx_pending_instr_tracker_pkg::*;
#(
   parameter int NUM_WARPS   = 8,
   parameter int NUM_COMMITS = 4,
   parameter int CTR_WIDTH   = PENDING_CTR_WIDTH,
   parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            issue_fire,
   input  logic [NW_WIDTH-1:0]             issue_wid,
   input  logic [NW_WIDTH-1:0]             full_wid,
   output logic                            full,
   input  logic [NUM_COMMITS-1:0]          commit_valid,
   input  logic [NUM_COMMITS-1:0]          commit_eop,
   input  logic [NUM_COMMITS*NW_WIDTH-1:0] commit_wid,
   input  logic [NW_WIDTH-1:0]             alm_empty_wid,
   output logic                            alm_empty,
`ifdef VX_PENDING_TRACKER_PERF_EN
   output logic [PERF_CTR_BITS-1:0]        perf_csr_stalls,
   output logic [PERF_CTR_BITS-1:0]        perf_full_stalls,
`endif
   output logic                            pending_any
);

   localparam int DEC_W = dec_width(NUM_COMMITS);
   localparam int SUM_W = CTR_WIDTH + DEC_W;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

   logic [CTR_WIDTH-1:0]       pending_p1     [NUM_WARPS];
   logic [CTR_WIDTH-1:0]       pending_nxt_p0 [NUM_WARPS];
   logic [DEC_W-1:0]           dec_p0         [NUM_WARPS];
   logic [NUM_WARPS*DEC_W-1:0] dec_flat_p0;
   logic [NUM_WARPS-1:0]       inc_p0;
   logic [NUM_WARPS-1:0]       underflow_p0;
   logic                       any_nxt_p0;

   // Issue into a saturated counter is dropped; over-decrement clamps to zero.
   function automatic logic [CTR_WIDTH-1:0] sat_next(input logic [CTR_WIDTH-1:0] cur,
                                                     input logic                 inc,
                                                     input logic [DEC_W-1:0]     dec);
      logic [SUM_W-1:0] total;
      total = SUM_W'(cur) + SUM_W'(inc && (cur != CTR_MAX));
      if (SUM_W'(dec) > total) begin
         return '0;
      end
      return CTR_WIDTH'(total - SUM_W'(dec));
   endfunction

   vx_commit_warp_decoder #(
      .NUM_WARPS   (NUM_WARPS),
      .NUM_COMMITS (NUM_COMMITS),
      .NW_WIDTH    (NW_WIDTH),
      .DEC_W       (DEC_W)
   ) u_decoder (
      .commit_valid (commit_valid),
      .commit_eop   (commit_eop),
      .commit_wid   (commit_wid),
      .dec          (dec_flat_p0)
   );

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_unpack
      assign dec_p0[w] = dec_flat_p0[w*DEC_W +: DEC_W];
   end

   // ---- p0: next-state counters from issue and commit events ----
   always_comb begin
      any_nxt_p0 = 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         inc_p0[w]         = issue_fire && (issue_wid == NW_WIDTH'(w));
         underflow_p0[w]   = SUM_W'(dec_p0[w]) > (SUM_W'(pending_p1[w]) + SUM_W'(inc_p0[w]));
         pending_nxt_p0[w] = sat_next(pending_p1[w], inc_p0[w], dec_p0[w]);
         any_nxt_p0        = any_nxt_p0 | (pending_nxt_p0[w] != '0);
      end
   end

   // ---- p1: registered counters ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            pending_p1[w] <= '0;
         end
         pending_any <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            pending_p1[w] <= pending_nxt_p0[w];
         end
         pending_any <= any_nxt_p0;
      end
   end

   // No same-cycle commit bypass: a draining warp stalls one extra cycle.
   assign full = (pending_p1[full_wid] == CTR_MAX);

   // The querying CSR counts itself, so "only one left" means drained.
   assign alm_empty = SUM_W'(pending_p1[alm_empty_wid])
                      <= (SUM_W'(dec_p0[alm_empty_wid]) + SUM_W'(1));

`ifdef VX_PENDING_TRACKER_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_csr_stalls  <= '0;
         perf_full_stalls <= '0;
      end else begin
         if (!alm_empty) begin
            perf_csr_stalls <= perf_csr_stalls + PERF_CTR_BITS'(1);
         end
         if (full) begin
            perf_full_stalls <= perf_full_stalls + PERF_CTR_BITS'(1);
         end
      end
   end
`endif

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            assert (!underflow_p0[w])
               else $error("pending counter underflow on warp %0d", w);
         end
         assert (!(issue_fire && (pending_p1[issue_wid] == CTR_MAX)))
            else $error("issue to saturated warp %0d", issue_wid);
      end
   end
`endif

endmodule

// File: tb/tb_vx_pending_instr_tracker.sv
// Directed bench for vx_pending_instr_tracker with a per-warp count model and an
// every-cycle compare; perf counters checked when VX_PENDING_TRACKER_PERF_EN is defined.
module tb_vx_pending_instr_tracker;
   import vx_pending_instr_tracker_pkg::*;

   localparam int NW   = 8;
   localparam int NC   = 4;
   localparam int WB   = 3;
   localparam int MAXC = 63;

   logic            clk = 1'b0;
   logic            reset;
   logic            issue_fire;
   logic [WB-1:0]   issue_wid;
   logic [WB-1:0]   full_wid;
   logic            full;
   logic [NC-1:0]   commit_valid;
   logic [NC-1:0]   commit_eop;
   logic [NC*WB-1:0] commit_wid;
   logic [WB-1:0]   alm_empty_wid;
   logic            alm_empty;
   logic            pending_any;
`ifdef VX_PENDING_TRACKER_PERF_EN
   logic [PERF_CTR_BITS-1:0] perf_csr_stalls;
   logic [PERF_CTR_BITS-1:0] perf_full_stalls;
`endif

   always #5 clk = ~clk;

   vx_pending_instr_tracker #(
      .NUM_WARPS   (NW),
      .NUM_COMMITS (NC),
      .CTR_WIDTH   (6),
      .NW_WIDTH    (WB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .issue_fire    (issue_fire),
      .issue_wid     (issue_wid),
      .full_wid      (full_wid),
      .full          (full),
      .commit_valid  (commit_valid),
      .commit_eop    (commit_eop),
      .commit_wid    (commit_wid),
      .alm_empty_wid (alm_empty_wid),
      .alm_empty     (alm_empty),
`ifdef VX_PENDING_TRACKER_PERF_EN
      .perf_csr_stalls  (perf_csr_stalls),
      .perf_full_stalls (perf_full_stalls),
`endif
      .pending_any   (pending_any)
   );

   int     checks = 0;
   int     errors = 0;
   int     cnt [NW];
   bit     exp_any;
   bit     model_on = 1'b0;
   longint m_csr;
   longint m_full;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int eop_hits(input int w);
      int n = 0;
      for (int i = 0; i < NC; i++) begin
         if (commit_valid[i] && commit_eop[i] && (int'(commit_wid[i*WB +: WB]) == w)) n++;
      end
      return n;
   endfunction

   function automatic bit exp_alm();
      int q = int'(alm_empty_wid);
      return (cnt[q] - eop_hits(q)) <= 1;
   endfunction

   function automatic bit exp_full();
      return cnt[int'(full_wid)] == MAXC;
   endfunction

   // Count model: each warp holds issued-minus-retired, saturating at MAXC.
   always @(posedge clk) begin : model
      int n;
      bit any;
      if (!reset) begin
         for (int w = 0; w < NW; w++) cnt[w] <= 0;
         exp_any  <= 1'b0;
         m_csr    <= 0;
         m_full   <= 0;
         model_on <= 1'b1;
      end else if (model_on) begin
         m_csr  <= m_csr + (exp_alm() ? 0 : 1);
         m_full <= m_full + (exp_full() ? 1 : 0);
         any = 1'b0;
         for (int w = 0; w < NW; w++) begin
            n = cnt[w] - eop_hits(w);
            if (issue_fire && int'(issue_wid) == w && cnt[w] < MAXC) n = n + 1;
            if (n < 0) n = 0;
            cnt[w] <= n;
            if (n != 0) any = 1'b1;
         end
         exp_any <= any;
      end
   end

   always @(negedge clk) begin
      if (model_on && reset) begin
         chk("cmp_full", full, exp_full());
         chk("cmp_alm_empty", alm_empty, exp_alm());
         chk("cmp_pending_any", pending_any, exp_any);
`ifdef VX_PENDING_TRACKER_PERF_EN
         chk("cmp_perf_csr", perf_csr_stalls, m_csr);
         chk("cmp_perf_full", perf_full_stalls, m_full);
`endif
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_ev();
      issue_fire   = 1'b0;
      commit_valid = '0;
      commit_eop   = '0;
   endtask

   initial begin
      reset = 1'b0;
      issue_fire = 1'b1; issue_wid = 3'd2;
      full_wid = '0; alm_empty_wid = '0;
      commit_valid = '0; commit_eop = '0; commit_wid = '0;
      repeat (3) step();
      reset = 1'b1;
      issue_fire = 1'b0;
      step();
      chk("reset_pending_any", pending_any, 1'b0);
      for (int q = 0; q < NW; q++) begin
         alm_empty_wid = WB'(q);
         full_wid      = WB'(q);
         #1;
         chk("reset_alm_empty", alm_empty, 1'b1);
         chk("reset_full", full, 1'b0);
         step();
      end
      // Warp 2 must start from zero: one issue leaves it drained-equivalent.
      issue_fire = 1'b1; issue_wid = 3'd2;
      step();
      clear_ev();
      alm_empty_wid = 3'd2;
      #1;
      chk("reset_wid2_zero", alm_empty, 1'b1);
      chk("pending_any_rise", pending_any, 1'b1);

      // Drain: 3 older instructions plus the CSR on warp 1.
      alm_empty_wid = 3'd1;
      issue_fire = 1'b1; issue_wid = 3'd1;
      repeat (4) step();
      clear_ev();
      commit_wid = {NC{3'd1}};
      commit_valid = 4'b0001; commit_eop = 4'b0001;
      #1; chk("drain_c1", alm_empty, 1'b0);
      step();
      commit_valid = 4'b0010; commit_eop = 4'b0010;
      #1; chk("drain_c2", alm_empty, 1'b0);
      step();
      commit_valid = 4'b0100; commit_eop = 4'b0100;
      #1; chk("drain_c3", alm_empty, 1'b1);
      step();
      clear_ev();
      #1;
      chk("drain_final_alm", alm_empty, 1'b1);
      chk("model_drain_cnt", cnt[1], 1);

      // Simultaneous issue and two commits on warp 0: 2 + 1 - 2 = 1.
      issue_fire = 1'b1; issue_wid = 3'd0;
      repeat (2) step();
      commit_wid = {NC{3'd0}};
      commit_valid = 4'b1001; commit_eop = 4'b1001;
      step();
      clear_ev();
      alm_empty_wid = 3'd0;
      #1;
      chk("simul_alm", alm_empty, 1'b1);
      chk("model_simul_cnt", cnt[0], 1);

      // Non-eop packet must not retire.
      issue_fire = 1'b1; issue_wid = 3'd5;
      step();
      clear_ev();
      commit_wid = {NC{3'd5}};
      commit_valid = 4'b0010; commit_eop = 4'b0000;
      step();
      clear_ev();
      issue_fire = 1'b1; issue_wid = 3'd5;
      step();
      clear_ev();
      alm_empty_wid = 3'd5;
      #1;
      chk("noneop_alm", alm_empty, 1'b0);
      chk("model_noneop_cnt", cnt[5], 2);

      // Saturation on warp 3.
      issue_fire = 1'b1; issue_wid = 3'd3;
      repeat (MAXC) step();
      clear_ev();
      full_wid = 3'd3; #1; chk("sat_full_w3", full, 1'b1);
      full_wid = 3'd4; #1; chk("sat_full_w4", full, 1'b0);
      full_wid = 3'd3;
      commit_wid = {NC{3'd3}};
      commit_valid = 4'b0100; commit_eop = 4'b0100;
      #1; chk("sat_no_bypass", full, 1'b1);
      step();
      clear_ev();
      #1; chk("sat_full_release", full, 1'b0);
      chk("model_sat_cnt", cnt[3], 62);
      alm_empty_wid = 3'd3;
      commit_valid = 4'b1111; commit_eop = 4'b1111;
      #1; chk("quad_commit_alm", alm_empty, 1'b0);
      step();
      clear_ev();
      chk("model_quad_cnt", cnt[3], 58);

      // Mid-operation reset discards every count.
      reset = 1'b0;
      step();
      reset = 1'b1;
      #1;
      chk("midreset_pending_any", pending_any, 1'b0);
      chk("midreset_alm_w3", alm_empty, 1'b1);
      chk("midreset_full_w3", full, 1'b0);
      issue_fire = 1'b1; issue_wid = 3'd3;
      step();
      clear_ev();
      chk("any_after_issue", pending_any, 1'b1);
      commit_wid = {NC{3'd3}};
      commit_valid = 4'b0001; commit_eop = 4'b0001;
      step();
      clear_ev();
      chk("any_after_drain", pending_any, 1'b0);

`ifdef VX_PENDING_TRACKER_PERF_EN
      reset = 1'b0;
      step();
      reset = 1'b1;
      alm_empty_wid = 3'd0;
      issue_fire = 1'b1; issue_wid = 3'd6;
      repeat (2) step();
      clear_ev();
      alm_empty_wid = 3'd6;
      repeat (10) step();
      alm_empty_wid = 3'd0;
      #1;
      chk("perf_csr_10", perf_csr_stalls, 10);
      chk("perf_full_0", perf_full_stalls, 0);
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vx_pending_instr_tracker.md
Name: vx_pending_instr_tracker

Overview:
- Per-warp count of instructions issued to execute units but not yet committed.
- Answers the CSR unit's "alm_empty" query (`sched_csr_if.alm_empty` / `alm_empty_wid`) so a CSR access to a warp waits until all older instructions of that warp have drained.
- Sits in the scheduler, between the issue fire point and the commit ports.
- Also back-pressures issue when a warp's counter would overflow.

Parameters:
- NUM_WARPS, `NUM_WARPS: number of tracked warps.
- NUM_COMMITS, 4: number of commit ports (one per execute block).
- CTR_WIDTH, 6: per-warp counter width; maximum in-flight count is 2^CTR_WIDTH-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- issue_fire  in  1  an instruction left issue this cycle
- issue_wid  in  `NW_WIDTH  warp of the issued instruction
- full_wid  in  `NW_WIDTH  warp being checked for issue eligibility
- full  out  1  counter of full_wid is at maximum; issue of that warp must stall
- commit_valid  in  NUM_COMMITS  commit handshake fired on port i
- commit_eop  in  NUM_COMMITS  last packet of the instruction on port i
- commit_wid  in  NUM_COMMITS*`NW_WIDTH  warp on port i
- alm_empty_wid  in  `NW_WIDTH  warp queried by the CSR unit
- alm_empty  out  1  the queried warp has no older instruction pending
- pending_any  out  1  registered: some warp has a nonzero counter

Behaviour:
- State: pending[NUM_WARPS][CTR_WIDTH].
- Reset (reset==0 sampled at a clk edge): all counters 0, pending_any=0.
  - Combinational outputs after reset: full=0, alm_empty=1.
  - A reset asserted mid-operation discards all counts; commits that arrive after reset are illegal and caught by assertion.
- A commit port decrements only when commit_valid[i] && commit_eop[i]. Non-eop packets are ignored.
- Per-warp next value = pending[w] + inc[w] - dec[w], where:
  - inc[w] = issue_fire && issue_wid==w.
  - dec[w] = popcount over ports i of (commit_valid[i] && commit_eop[i] && commit_wid[i]==w), range 0..NUM_COMMITS.
  - The sum is computed at CTR_WIDTH+clog2(NUM_COMMITS+1) bits and truncated to CTR_WIDTH.
- Same-cycle issue and commit to the same warp: net change applied in one edge (for example, 3 + 1 - 1 = 3).
- Underflow (dec[w] > pending[w]+inc[w]): illegal. Simulation assertion with warp id; RTL clamps to 0.
- full = (pending[full_wid] == all-ones). Combinational, no bypass of same-cycle commits. This is conservative and costs one stall cycle.
- issue_fire while full for issue_wid: illegal. Assertion; the counter holds at max.
- The CSR request is treated as already issued (its own issue_fire has fired), so it counts itself. alm_empty is therefore combinational and true when either:
  - pending[alm_empty_wid] - dec[alm_empty_wid] <= 1, excluding a same-cycle inc, or
  - pending is 0.
  - This makes alm_empty true when only the CSR instruction itself remains. Commits in the current cycle are credited immediately, so the CSR can proceed in the cycle its predecessor commits.
- pending_any = registered OR-reduce of the next-state counters. It updates one cycle after the change.
- Latency: counter update 1 cycle; full and alm_empty 0 cycles from inputs.

Optional Feature:
- Macro: VX_PENDING_TRACKER_PERF_EN.
- Defined:
  - Adds output perf_csr_stalls (`PERF_CTR_BITS), counting cycles where alm_empty==0.
  - Adds output perf_full_stalls, counting cycles where full==1.
  - Both counters reset to 0 and wrap at 2^`PERF_CTR_BITS.
- Undefined: ports and counters are absent; the core behaviour is identical.

Decomposition:
- VX_gpu_pkg gains a constant PENDING_CTR_WIDTH=6 and a typedef pending_ctr_t = logic [PENDING_CTR_WIDTH-1:0].
- The popcount-per-warp decoder is natural as one sub-module, vx_commit_warp_decoder. It converts NUM_COMMITS (valid, eop, wid) tuples into a NUM_WARPS x clog2(NUM_COMMITS+1) decrement vector.

Test Plan:
- Reset hold: reset=0 for 3 cycles while driving issue_fire=1, wid=2 -> pending[2]=0 after release; alm_empty=1 for every wid; pending_any=0.
- Drain: issue 3 instructions to wid 1, then issue the CSR (count=4); commit eop on ports 0, 1, 2 in separate cycles -> alm_empty(wid 1) rises in the cycle of the third commit and not before; the final count is 1.
- Simultaneous events: count[0]=2, same cycle issue_fire wid 0 plus eop commits on ports 0 and 3 for wid 0 -> count[0]=1 next cycle.
- Non-eop filter: commit_valid=1, eop=0 for wid 5 with count 1 -> count stays 1.
- Saturation: 63 issues to wid 3 -> full=1 when full_wid=3 and 0 for full_wid=4; one eop commit -> full=0 on the next cycle.
- Perf (macro defined): hold alm_empty=0 for 10 cycles -> perf_csr_stalls=10.
